// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and a parity helper.
// The receiver uses these, and a future transmitter is meant to use them as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;
    localparam int LAST_TICK  = OVERSAMPLE - 1;
    localparam int DATA_BITS  = 8;

    // Returns 1 when the received parity bit does not match the data under the selected sense.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic p,
                                             input logic odd);
        return (^{data, p}) != odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a one-cycle pulse every CLK_DIV clocks, with a synchronous clear
// so the phase can be realigned to a detected start edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick = (cnt_q == CW'(CLK_DIV - 1));
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: 1 start, 8 data bits LSB first, optional parity, 1 stop.
// Each frame result is presented with a one-cycle data_valid strobe plus parity/framing flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    uart_state_e state_q, state_d;
    logic        sync_q, sync_d;
    logic        rx_s_q, rx_s_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_err_q, par_err_d;
    logic        armed_q, armed_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        parity_error_q, parity_error_d;
    logic        framing_error_q, framing_error_d;
    logic        tick;
    logic        baud_clear;

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            sync_q          <= 1'b1;
            rx_s_q          <= 1'b1;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_err_q       <= 1'b0;
            armed_q         <= 1'b0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            rx_s_q          <= rx_s_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            par_err_q       <= par_err_d;
            armed_q         <= armed_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        sync_d          = rx;
        rx_s_d          = sync_q;
        tick_cnt_d      = tick_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        par_err_d       = par_err_q;
        armed_d         = armed_q | rx_s_q;
        data_out_d      = data_out_q;
        data_valid_d    = 1'b0;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'(MID_SAMPLE)) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                            par_err_d = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'(LAST_TICK)) begin
                        shift_d[bit_cnt_q] = rx_s_q;
                        tick_cnt_d         = '0;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == 4'(LAST_TICK)) begin
                        par_err_d  = parity_mismatch(shift_q, rx_s_q, PARITY_ODD != 0);
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'(LAST_TICK)) begin
                        // A low stop bit leaves the receiver disarmed so a held-low break yields one frame.
                        data_out_d      = shift_q;
                        parity_error_d  = par_err_q;
                        framing_error_d = ~rx_s_q;
                        data_valid_d    = 1'b1;
                        armed_d         = rx_s_q;
                        tick_cnt_d      = '0;
                        state_d         = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        baud_clear    = (state_q == IDLE);
        data_out      = data_out_q;
        data_valid    = data_valid_q;
        parity_error  = parity_error_q;
        framing_error = framing_error_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three instances (even/odd parity at CLK_DIV=1, even at CLK_DIV=3),
// directed frames push expected results, per-instance monitors pop and compare on data_valid.
module tb_uart_rx;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        int         start;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a;
    logic       rx_c;
    logic [7:0] data_out_a, data_out_b, data_out_c;
    logic       dv_a, dv_b, dv_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       busy_a, busy_b, busy_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    int checks    = 0;
    int errors    = 0;
    int cycle_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    uart_rx #(.CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a),
        .data_out(data_out_a), .data_valid(dv_a), .parity_error(pe_a),
        .framing_error(fe_a), .busy(busy_a)
    );

    uart_rx #(.CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_a),
        .data_out(data_out_b), .data_valid(dv_b), .parity_error(pe_b),
        .framing_error(fe_b), .busy(busy_b)
    );

    uart_rx #(.CLK_DIV(3), .PARITY_EN(1), .PARITY_ODD(0)) dut_c (
        .clk(clk), .reset(reset), .rx(rx_c),
        .data_out(data_out_c), .data_valid(dv_c), .parity_error(pe_c),
        .framing_error(fe_c), .busy(busy_c)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic checkWindow(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic checkFrame(input string tag, input exp_t e, input logic [7:0] d,
                              input logic pe, input logic fe);
        checkOutput({tag, "_data"}, d, e.data);
        checkOutput({tag, "_parity_error"}, pe, e.pe);
        checkOutput({tag, "_framing_error"}, fe, e.fe);
        checkWindow({tag, "_latency"}, cycle_cnt - e.start, e.lat - 1, e.lat + 1);
    endtask

    // Monitors: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dv_a) begin
            checkOutput("a_strobe_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                checkFrame("a", e_a, data_out_a, pe_a, fe_a);
            end
        end
    end

    always @(negedge clk) begin
        if (dv_b) begin
            checkOutput("b_strobe_expected", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                checkFrame("b", e_b, data_out_b, pe_b, fe_b);
            end
        end
    end

    always @(negedge clk) begin
        if (dv_c) begin
            checkOutput("c_strobe_expected", int'(q_c.size() > 0), 1);
            if (q_c.size() > 0) begin
                e_c = q_c.pop_front();
                checkFrame("c", e_c, data_out_c, pe_c, fe_c);
            end
        end
    end

    task automatic driveLine(input bit to_c, input logic v, input int clocks);
        if (to_c) rx_c = v;
        else      rx_a = v;
        repeat (clocks) @(negedge clk);
    endtask

    // Sends one full frame and queues the hand-computed result; latency is 168*CLK_DIV plus
    // two synchronizer stages and one output register, measured from the start-bit drive.
    task automatic applyStimulus(input bit to_c, input logic [7:0] data, input logic par,
                                 input logic stop, input logic pe_even, input logic pe_odd,
                                 input logic fe);
        int   bp;
        exp_t e;
        bp      = to_c ? 48 : 16;
        e.data  = data;
        e.fe    = fe;
        e.start = cycle_cnt;
        e.lat   = to_c ? (168 * 3 + 3) : (168 + 3);
        e.pe    = pe_even;
        if (to_c) begin
            q_c.push_back(e);
        end else begin
            q_a.push_back(e);
            e.pe = pe_odd;
            q_b.push_back(e);
        end
        driveLine(to_c, 1'b0, bp);
        for (int i = 0; i < 8; i++) driveLine(to_c, data[i], bp);
        driveLine(to_c, par, bp);
        driveLine(to_c, stop, bp);
    endtask

    initial begin
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_c  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_out", data_out_a, 8'h00);
        checkOutput("reset_data_valid", dv_a, 0);
        checkOutput("reset_parity_error", pe_a, 0);
        checkOutput("reset_framing_error", fe_a, 0);
        checkOutput("reset_busy", busy_a, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] clean frame and parity checks");
        applyStimulus(1'b0, 8'h18, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        driveLine(1'b0, 1'b1, 32);
        applyStimulus(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        driveLine(1'b0, 1'b1, 32);

        $display("[TB] framing error followed by held-low line");
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        driveLine(1'b0, 1'b0, 40 * 16);
        checkOutput("break_busy_a", busy_a, 0);
        driveLine(1'b0, 1'b1, 48);
        applyStimulus(1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        driveLine(1'b0, 1'b1, 32);

        $display("[TB] glitch on the line");
        driveLine(1'b0, 1'b0, 4);
        checkOutput("glitch_busy_during", busy_a, 1);
        driveLine(1'b0, 1'b1, 32);
        checkOutput("glitch_busy_after", busy_a, 0);
        checkOutput("glitch_data_out_a", data_out_a, 8'h81);
        checkOutput("glitch_data_out_b", data_out_b, 8'h81);

        $display("[TB] back-to-back frames at CLK_DIV=3");
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        driveLine(1'b1, 1'b1, 96);

        $display("[TB] reset in the middle of data bit 4");
        driveLine(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) driveLine(1'b0, 1'b0, 16);
        driveLine(1'b0, 1'b1, 8);
        checkOutput("pre_reset_busy", busy_a, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_data_out", data_out_a, 8'h00);
        checkOutput("midreset_data_valid", dv_a, 0);
        checkOutput("midreset_parity_error", pe_b, 0);
        checkOutput("midreset_framing_error", fe_a, 0);
        checkOutput("midreset_busy", busy_a, 0);
        reset = 1'b0;
        driveLine(1'b0, 1'b1, 64);
        checkOutput("post_reset_busy", busy_a, 0);
        applyStimulus(1'b0, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        driveLine(1'b0, 1'b1, 200);

        checkOutput("a_pending_frames", q_a.size(), 0);
        checkOutput("b_pending_frames", q_b.size(), 0);
        checkOutput("c_pending_frames", q_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
